uart_tx_sched: RTL

//  Transmit-side scheduler between the UART TX FIFO and the UART transmitter.
//  It is the FIFO's sole reader. It pops one byte when data is available, loads
//  the transmitter, and waits for frame completion. It then enforces an

---
 rtl/uart_tx_sched.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Transmit-side scheduler between the UART TX FIFO and the UART transmitter.
//   It is the only reader of the FIFO. For each frame it pops one byte, latches
//   it into tx_din, and issues a one-cycle tx_start. It then waits for tx_done
//   and holds an idle gap of GAP_TICKS s_ticks before the next frame. A watchdog
//   counting s_ticks in WAIT raises a sticky err if the transmitter never
//   finishes.
//
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   enable       allow new frames to start (sampled in IDLE only)
//   s_tick       baud oversample tick, 1-cycle pulse
//   fifo_empty   TX FIFO empty flag (sampled in IDLE only)
//   fifo_data    TX FIFO read data, valid 1 cycle after fifo_rd_en
//   fifo_rd_en   FIFO pop strobe (state POP)
//   tx_start     transmitter start pulse (state START)
//   tx_din       byte to transmit, held until the next load
//   tx_done      transmitter frame-complete pulse (honoured in WAIT only)
//   err_clr      clears sticky err
//   busy         high whenever the scheduler is not IDLE
//   err          sticky watchdog timeout flag
//   frame_cnt    completed frames, wraps at 16 bits
module uart_tx_sched #(
  parameter int DBIT          = 8,
  parameter int GAP_TICKS     = 16,
  parameter int TIMEOUT_TICKS = 320
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_data,
  output logic            fifo_rd_en,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_din,
  input  logic            tx_done,
  input  logic            err_clr,
  output logic            busy,
  output logic            err,
  output logic [15:0]     frame_cnt
);

  // Counter widths; GAP_TICKS == 0 still needs a 1-bit (unused) counter.
  localparam int GW       = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int WW       = $clog2(TIMEOUT_TICKS + 1);
  localparam int GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
  localparam int WD_LAST  = (TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]    state;
  logic [GW-1:0] gap_cnt;
  logic [WW-1:0] wd_cnt;

  assign fifo_rd_en = (state == S_POP);
  assign tx_start   = (state == S_START);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      tx_din    <= '0;
      err       <= 1'b0;
      frame_cnt <= '0;
      gap_cnt   <= '0;
      wd_cnt    <= '0;
    end else begin
      // The timeout branch below assigns err later, so a same-cycle set wins.
      if (err_clr) begin
        err <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (enable && !fifo_empty) begin
            state <= S_POP;
          end
        end

        S_POP: begin
          state <= S_LATCH;
        end

        S_LATCH: begin
          tx_din <= fifo_data;
          state  <= S_START;
        end

        S_START: begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end

        S_WAIT: begin
          // tx_done takes priority over a coincident watchdog expiry.
          if (tx_done) begin
            frame_cnt <= frame_cnt + 16'd1;
            gap_cnt   <= '0;
            state     <= (GAP_TICKS == 0) ? S_IDLE : S_GAP;
          end else if (s_tick) begin
            // Pre-increment value compared so the counter never exceeds its range.
            if (wd_cnt == WW'(WD_LAST)) begin
              err   <= 1'b1;
              state <= S_IDLE;
            end else begin
              wd_cnt <= wd_cnt + WW'(1);
            end
          end
        end

        S_GAP: begin
          if (s_tick) begin
            if (gap_cnt == GW'(GAP_LAST)) begin
              state <= S_IDLE;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
